// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge detector: two line buffers feed a 3x3 window, two
// free-running pipeline stages produce saturated |Gx|+|Gy| and a threshold bit.
module sobel_edge #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int THRESH = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] gray_in,
    input  logic       valid_in,
    input  logic       sof_in,
    output logic [7:0] edge_mag,
    output logic       edge_bit,
    output logic       valid_out,
    output logic       eof_out
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic          last_col, last_row, trig_c, eof_c;

    logic [7:0] lb0 [IMG_W];
    logic [7:0] lb1 [IMG_W];
    logic [7:0] lb0_rd, lb1_rd;

    logic [2:0][2:0][7:0] p;
    logic [2:0]           vld_pipe, eof_pipe;

    logic signed [10:0] gx_c, gy_c, gx_r, gy_r;
    logic        [10:0] ax, ay, sum;
    logic        [7:0]  mag_c;

    // sof overrides the counters so a new frame always lands at (0,0)
    assign cur_col  = sof_in ? '0 : col;
    assign cur_row  = sof_in ? '0 : row;
    assign last_col = (cur_col == CW'(IMG_W - 1));
    assign last_row = (cur_row == RW'(IMG_H - 1));
    assign trig_c   = valid_in && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    assign eof_c    = last_row && last_col;

    assign lb0_rd = lb0[cur_col];
    assign lb1_rd = lb1[cur_col];

    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb1[cur_col] <= gray_in;
            lb0[cur_col] <= lb1_rd;
        end
    end

    function automatic logic signed [10:0] ext(input logic [7:0] v);
        return {3'b000, v};
    endfunction

    assign gx_c = (ext(p[0][2]) + (ext(p[1][2]) <<< 1) + ext(p[2][2]))
                - (ext(p[0][0]) + (ext(p[1][0]) <<< 1) + ext(p[2][0]));
    assign gy_c = (ext(p[2][0]) + (ext(p[2][1]) <<< 1) + ext(p[2][2]))
                - (ext(p[0][0]) + (ext(p[0][1]) <<< 1) + ext(p[0][2]));

    assign ax    = gx_r[10] ? 11'(-gx_r) : 11'(gx_r);
    assign ay    = gy_r[10] ? 11'(-gy_r) : 11'(gy_r);
    assign sum   = ax + ay;
    assign mag_c = (sum > 11'd255) ? 8'hFF : sum[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            p        <= '0;
            vld_pipe <= '0;
            eof_pipe <= '0;
            gx_r     <= '0;
            gy_r     <= '0;
            edge_mag <= '0;
            edge_bit <= 1'b0;
        end else begin
            // the pipeline never stalls; idle input cycles become bubbles
            vld_pipe <= {vld_pipe[1:0], trig_c};
            eof_pipe <= {eof_pipe[1:0], trig_c && eof_c};
            if (valid_in) begin
                col <= last_col ? '0 : cur_col + 1'b1;
                row <= last_col ? (last_row ? '0 : cur_row + 1'b1) : cur_row;
                for (int r = 0; r < 3; r++) begin
                    p[r][0] <= p[r][1];
                    p[r][1] <= p[r][2];
                end
                p[0][2] <= lb0_rd;
                p[1][2] <= lb1_rd;
                p[2][2] <= gray_in;
            end
            gx_r <= gx_c;
            gy_r <= gy_c;
            if (vld_pipe[1]) begin
                edge_mag <= mag_c;
                edge_bit <= (mag_c >= 8'(THRESH));
            end
        end
    end

    assign valid_out = vld_pipe[2];
    assign eof_out   = eof_pipe[2];

endmodule

// File: tb/tb_sobel_edge.sv
// Directed bench for sobel_edge on a 4x4 image; expected magnitudes are
// hand-computed per frame pattern and checked with exact output timing.
module tb_sobel_edge;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] gray_in = '0;
    logic       valid_in = 1'b0;
    logic       sof_in = 1'b0;
    logic [7:0] edge_mag;
    logic       edge_bit, valid_out, eof_out;

    always #5 clk = ~clk;

    sobel_edge #(.IMG_W(4), .IMG_H(4), .THRESH(128)) dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .valid_in(valid_in),
        .sof_in(sof_in), .edge_mag(edge_mag), .edge_bit(edge_bit),
        .valid_out(valid_out), .eof_out(eof_out)
    );

    typedef struct {
        logic [7:0] mag;
        logic       eb;
        logic       eof;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         nvec = 0;
    int         nmis = 0;
    logic [7:0] last_mag = '0;
    logic       last_bit = 1'b0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        nvec++;
        assert (got === want) else begin
            nmis++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // one clock; outputs sampled on the falling edge against the expectation queue
    task automatic tick();
        exp_t e;
        logic exp_v;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        chk("valid_out", 16'(valid_out), 16'(exp_v));
        if (exp_v) begin
            e = exp_q.pop_front();
            chk("edge_mag", 16'(edge_mag), 16'(e.mag));
            chk("edge_bit", 16'(edge_bit), 16'(e.eb));
            chk("eof_out", 16'(eof_out), 16'(e.eof));
            last_mag = e.mag;
            last_bit = e.eb;
        end else if (!valid_out) begin
            chk("hold", 16'({edge_mag, edge_bit, eof_out}), 16'({last_mag, last_bit, 1'b0}));
        end
    endtask

    function automatic logic [7:0] pix(input int mode, input int r, input int c);
        case (mode)
            0:       return 8'd100;
            1:       return (c >= 2) ? 8'd255 : 8'd0;
            2:       return 8'(10 * c);
            3:       return 8'(20 * c);
            4:       return 8'(20 * r);
            5:       return 8'd50;
            6:       return 8'd200;
            default: return 8'd0;
        endcase
    endfunction

    task automatic drive(input logic [7:0] g, input logic s, input logic trig,
                         input logic [7:0] m, input logic b, input logic eof);
        exp_t e;
        valid_in = 1'b1;
        gray_in  = g;
        sof_in   = s;
        if (trig) begin
            e.mag = m; e.eb = b; e.eof = eof; e.due = cyc + 3;
            exp_q.push_back(e);
        end
        tick();
        valid_in = 1'b0;
        sof_in   = 1'b0;
    endtask

    task automatic frame(input int mode, input logic [7:0] m, input logic b,
                         input logic gaps, input int npix);
        for (int idx = 0; idx < npix; idx++) begin
            int r, c, g;
            r = idx / 4;
            c = idx % 4;
            if (gaps) begin
                g = $urandom_range(0, 3);
                repeat (g) tick();
            end
            drive(pix(mode, r, c), idx == 0, (r >= 2) && (c >= 2), m, b, (r == 3) && (c == 3));
        end
    endtask

    task automatic drain();
        repeat (4) tick();
        chk("drain", 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 16'(valid_out), 16'd0);
        chk("rst_mag", 16'(edge_mag), 16'd0);
        chk("rst_bit", 16'(edge_bit), 16'd0);
        chk("rst_eof", 16'(eof_out), 16'd0);
        rst = 1'b0;
        repeat (2) tick();

        frame(0, 8'd0, 1'b0, 1'b0, 16);     // uniform
        drain();
        frame(1, 8'd255, 1'b1, 1'b0, 16);   // step, saturates
        drain();
        frame(2, 8'd80, 1'b0, 1'b0, 16);    // ramp 10*c
        drain();
        frame(3, 8'd160, 1'b1, 1'b0, 16);   // ramp 20*c
        drain();
        frame(4, 8'd160, 1'b1, 1'b0, 16);   // vertical ramp
        drain();
        frame(6, 8'd0, 1'b0, 1'b0, 7);      // aborted partial frame
        frame(5, 8'd0, 1'b0, 1'b0, 16);
        drain();
        frame(1, 8'd255, 1'b1, 1'b1, 16);   // step with idle gaps
        drain();

        // reset while (2,2) is on the output and (2,3) is still in flight
        frame(1, 8'd255, 1'b1, 1'b0, 13);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 16'(valid_out), 16'd0);
        chk("mid_rst_mag", 16'(edge_mag), 16'd0);
        chk("mid_rst_bit", 16'(edge_bit), 16'd0);
        chk("mid_rst_eof", 16'(eof_out), 16'd0);
        exp_q.delete();
        last_mag = '0;
        last_bit = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        frame(1, 8'd255, 1'b1, 1'b0, 16);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
